// File: rtl/mips789_bus_pkg.sv
// Shared definitions for the MEM-stage data bus bridge: FSM encoding and
// byte-lane conventions of the external request/acknowledge bus.
package mips789_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

    // Big-endian lanes: enable bit 3 covers data bits 31:24.
    localparam int unsigned BUS_LANE_MSB_ENABLE = 3;
    localparam logic [3:0]  BUS_BE_ALL_LANES    = 4'hF;

    function automatic logic [3:0] bus_be_for(input logic       is_write,
                                              input logic [3:0] wr_en);
        return is_write ? wr_en : BUS_BE_ALL_LANES;
    endfunction

endpackage

// File: rtl/dmem_bus_timer.sv
// 8-bit saturating cycle counter that flags when an outstanding bus access
// has waited TIMEOUT_CYC cycles without acknowledge.
module dmem_bus_timer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // The current enabled cycle is included, so the FSM can leave BUSY on the
    // very cycle the waited count reaches the limit.
    always_comb begin
        hit = en && !clr && (count_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the single-cycle MEM-stage data port onto a request/acknowledge bus,
// stalling the pipeline with pause until each access completes or times out.
module dmem_bus_bridge
    import mips789_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wr_en,
    input  logic        core_rd,
    output logic [31:0] core_rdata,
    output logic        pause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    bus_state_e  state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] core_rdata_q, core_rdata_d;

    logic req_present;
    logic is_write;
    logic timer_clr;
    logic timer_en;
    logic timer_hit;

    always_comb begin
        is_write    = |core_wr_en;
        req_present = core_rd | is_write;
        timer_clr   = (state_q != ST_BUSY);
        timer_en    = (state_q == ST_BUSY) && !bus_ack;
    end

    dmem_bus_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(timer_clr),
        .en (timer_en),
        .hit(timer_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= 4'h0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            bus_err_q    <= 1'b0;
            core_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_err_q    <= bus_err_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_present) state_d = ST_BUSY;
            ST_BUSY: if (bus_ack || timer_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pause        = 1'b0;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_err_d    = 1'b0;
        core_rdata_d = core_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_present) begin
                    pause       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_write;
                    bus_be_d    = bus_be_for(is_write, core_wr_en);
                    bus_addr_d  = core_addr & ~32'h3;
                    bus_wdata_d = core_wdata;
                end
            end
            ST_BUSY: begin
                pause = 1'b1;
                // An acknowledge in the same cycle as the limit still completes normally.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) core_rdata_d = bus_rdata;
                end else if (timer_hit) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!bus_we_q) core_rdata_d = ERR_RDATA;
                end
            end
            default: begin
                pause = 1'b0;
            end
        endcase
        if (!rst) pause = 1'b0;
    end

    assign core_rdata = core_rdata_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_be     = bus_be_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Randomized bench for dmem_bus_bridge against a per-access timeline model.
module tb_dmem_bus_bridge;

    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_wr_en;
    logic        core_rd, pause;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_rdata;

    dmem_bus_bridge #(.TIMEOUT_CYC(T), .ERR_RDATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_wr_en(core_wr_en),
        .core_rd(core_rd), .core_rdata(core_rdata), .pause(pause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        core_rd    = 1'b0;
        core_wr_en = 4'h0;
        core_addr  = $urandom;
        core_wdata = $urandom;
    endtask

    // k = cycle (1-based after bus_req rises) in which ack arrives; 0 = never.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wr_en, input logic rd, input int k);
        int          kend;
        logic        wr;
        logic [31:0] rdv;
        kend = (k == 0) ? T : k;
        wr   = |wr_en;
        rdv  = $urandom;
        core_addr = addr; core_wdata = wdata; core_wr_en = wr_en; core_rd = rd;
        #1;
        chk("pause_first", 32'(pause), 32'd1);
        chk("req_not_yet", 32'(bus_req), 32'd0);
        for (int i = 1; i <= kend + 1; i++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (i <= kend) begin
                chk("pause_busy", 32'(pause), 32'd1);
                chk("bus_req_busy", 32'(bus_req), 32'd1);
                chk("bus_err_busy", 32'(bus_err), 32'd0);
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_be", 32'(bus_be), wr ? 32'(wr_en) : 32'hF);
                chk("bus_we", 32'(bus_we), 32'(wr));
                if (wr) chk("bus_wdata", bus_wdata, wdata);
                if (i == k) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdv;
                end else begin
                    bus_rdata = $urandom;
                end
            end else begin
                chk("pause_done", 32'(pause), 32'd0);
                chk("bus_req_done", 32'(bus_req), 32'd0);
                chk("bus_err_done", 32'(bus_err), (k == 0) ? 32'd1 : 32'd0);
                idle_inputs();
            end
        end
        if (!wr) model_rdata = (k == 0) ? ERR : rdv;
        @(negedge clk);
        chk("pause_after", 32'(pause), 32'd0);
        chk("core_rdata", core_rdata, model_rdata);
        chk("bus_err_after", 32'(bus_err), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_core_rdata", core_rdata, 32'd0);
    endtask

    initial begin
        logic [3:0] we_r;
        int         k_r;
        rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0; model_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(negedge clk);
        core_rd = 1'b1;
        #1;
        chk("rst_pause_forced", 32'(pause), 32'd0);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("idle_pause", 32'(pause), 32'd0);

        // directed cases
        access(32'h0000_0104, 32'h0, 4'h0, 1'b1, 3);
        access(32'h0000_0202, 32'h5A5A_5A5A, 4'b0010, 1'b0, 1);
        access(32'h0000_0308, 32'h0, 4'h0, 1'b1, 0);
        access(32'h0000_0400, 32'h0, 4'h0, 1'b1, 2);
        access(32'h0000_0404, 32'h1234_5678, 4'b1100, 1'b1, 1);

        // spurious acknowledge while idle
        bus_ack = 1'b1; bus_rdata = 32'hBAAD_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("spur_pause", 32'(pause), 32'd0);
        chk("spur_bus_req", 32'(bus_req), 32'd0);
        chk("spur_rdata", core_rdata, model_rdata);
        @(negedge clk);
        chk("spur_rdata2", core_rdata, model_rdata);

        // reset during BUSY followed by a late acknowledge
        core_addr = 32'h0000_0500; core_rd = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", 32'(bus_req), 32'd1);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("mid_rst_pause", 32'(pause), 32'd0);
        check_reset_outputs();
        rst = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_ack = 1'b0;
        model_rdata = 32'h0;
        chk("late_ack_req", 32'(bus_req), 32'd0);
        chk("late_ack_pause", 32'(pause), 32'd0);
        chk("late_ack_rdata", core_rdata, model_rdata);

        // randomized accesses, some back-to-back
        for (int n = 0; n < 40; n++) begin
            we_r = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            k_r  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
            access($urandom, $urandom, we_r, (we_r == 4'h0) ? 1'b1 : 1'($urandom), k_r);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("gap_pause", 32'(pause), 32'd0);
                chk("gap_rdata", core_rdata, model_rdata);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
